// File: rtl/jstk_poll_scheduler.sv
// Round-robin poll scheduler sharing one SPI master among four joystick channels.
// One 5-byte transfer per poll tick; replies are unpacked into per-channel X/Y/button registers.
module jstk_poll_scheduler #(
  parameter int N_CH      = 4,
  parameter int POLL_DIV  = 100000,
  parameter int SETUP_CYC = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     ch_en,
  input  logic [2*N_CH-1:0]   led_cmd,
  input  logic                spi_busy,
  input  logic                spi_done,
  input  logic [39:0]         spi_rx,
  output logic                spi_start,
  output logic [1:0]          spi_sel,
  output logic [39:0]         spi_tx,
  output logic [10*N_CH-1:0]  x_pos,
  output logic [10*N_CH-1:0]  y_pos,
  output logic [3*N_CH-1:0]   btn,
  output logic [N_CH-1:0]     upd,
  output logic [N_CH-1:0]     timeout_err
);
  localparam int TICK_W = $clog2(POLL_DIV + 1);
  localparam int SET_W  = $clog2(SETUP_CYC + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, START, WAIT} state_t;
  state_t state, state_n;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [SET_W-1:0]  setup_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [1:0]        last, cur, pick, cand;
  logic              found;
  logic              sel_load, start_fire, done_take, tmo_hit;
  logic              rx_unused;

  // Only the X/Y/button fields of the reply frame carry information.
  assign rx_unused = ^{spi_rx[31:26], spi_rx[15:10], spi_rx[7:3]};

  assign tick = (tick_cnt == TICK_W'(POLL_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Search starts just after the last-served channel; the 2-bit add wraps naturally.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = last + 2'(i);
      if (!found && ch_en[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    sel_load   = 1'b0;
    start_fire = 1'b0;
    done_take  = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (tick && found) begin
          sel_load = 1'b1;
          state_n  = SETUP;
        end
      end
      SETUP: begin
        if (setup_cnt == SET_W'(SETUP_CYC - 1)) state_n = START;
      end
      START: begin
        if (!spi_busy) begin
          start_fire = 1'b1;
          state_n    = WAIT;
        end
      end
      WAIT: begin
        if (spi_done) begin
          done_take = 1'b1;
          state_n   = IDLE;
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // All outputs are registered so spi_start cannot glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      setup_cnt   <= '0;
      tmo_cnt     <= '0;
      last        <= 2'd3;
      cur         <= '0;
      spi_start   <= 1'b0;
      spi_sel     <= '0;
      spi_tx      <= '0;
      x_pos       <= '0;
      y_pos       <= '0;
      btn         <= '0;
      upd         <= '0;
      timeout_err <= '0;
    end else begin
      spi_start <= start_fire;
      upd       <= '0;
      if (state == SETUP) setup_cnt <= setup_cnt + SET_W'(1);
      if (state == WAIT)  tmo_cnt   <= tmo_cnt + TMO_W'(1);
      if (sel_load) begin
        cur       <= pick;
        spi_sel   <= pick;
        spi_tx    <= {6'b100000, led_cmd[{pick, 1'b0} +: 2], 32'h0};
        setup_cnt <= '0;
      end
      if (start_fire) tmo_cnt <= '0;
      if (done_take) begin
        x_pos[int'(cur) * 10 +: 10] <= {spi_rx[25:24], spi_rx[39:32]};
        y_pos[int'(cur) * 10 +: 10] <= {spi_rx[9:8], spi_rx[23:16]};
        btn[int'(cur) * 3 +: 3]     <= spi_rx[2:0];
        upd[cur]                    <= 1'b1;
        timeout_err[cur]            <= 1'b0;
        last                        <= cur;
      end
      if (tmo_hit) begin
        timeout_err[cur] <= 1'b1;
        last             <= cur;
      end
    end
  end

endmodule

// File: tb/tb_jstk_poll_scheduler.sv
// Bench for jstk_poll_scheduler: transaction-timeline reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized run with a random SPI responder.
`timescale 1ns/1ps
module tb_jstk_poll_scheduler;
  localparam int POLL_DIV  = 16;
  localparam int SETUP_CYC = 2;
  localparam int TIMEOUT   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  ch_en = '0;
  logic [7:0]  led_cmd = '0;
  logic        spi_busy;
  logic        spi_done = 1'b0;
  logic [39:0] spi_rx = '0;
  logic        spi_start;
  logic [1:0]  spi_sel;
  logic [39:0] spi_tx;
  logic [39:0] x_pos, y_pos;
  logic [11:0] btn;
  logic [3:0]  upd, timeout_err;

  int checks = 0;
  int failures = 0;

  jstk_poll_scheduler #(
    .N_CH(4), .POLL_DIV(POLL_DIV), .SETUP_CYC(SETUP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .led_cmd(led_cmd),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx(spi_rx),
    .spi_start(spi_start), .spi_sel(spi_sel), .spi_tx(spi_tx),
    .x_pos(x_pos), .y_pos(y_pos), .btn(btn), .upd(upd), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SPI responder ----------------
  int          resp_lat = 20;
  logic [3:0]  silent = '0;
  logic        force_busy = 1'b0;
  logic        rand_mode = 1'b0;
  logic        resp_busy = 1'b0;
  logic [39:0] fixed_rx = 40'h3C_02_10_01_05;
  int          pend_cnt = 0;

  assign spi_busy = force_busy | resp_busy;

  always @(negedge clk) begin
    if (rst) begin
      resp_busy = 1'b0;
      spi_done  = 1'b0;
      pend_cnt  = 0;
    end else begin
      spi_done = 1'b0;
      if (spi_start) begin
        pend_cnt  = rand_mode ? int'($urandom_range(1, 80)) : resp_lat;
        resp_busy = !silent[spi_sel];
      end else if (resp_busy && !rand_mode) begin
        pend_cnt--;
        if (pend_cnt <= 0) begin
          resp_busy = 1'b0;
          spi_done  = 1'b1;
          spi_rx    = fixed_rx;
        end
      end else if (resp_busy) begin
        pend_cnt--;
        if (pend_cnt <= 0) begin
          resp_busy = 1'b0;
          spi_done  = 1'b1;
          spi_rx    = {8'($urandom), 32'($urandom)};
        end else if ($urandom_range(0, 7) == 0) begin
          spi_rx = {8'($urandom), 32'($urandom)};
        end
      end else if (rand_mode) begin
        if ($urandom_range(0, 49) == 0) begin
          spi_done = 1'b1;
          spi_rx   = {8'($urandom), 32'($urandom)};
        end
        resp_busy = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // ---------------- Reference model: one transaction timeline ----------------
  int          m_cnt, m_n, m_last, m_cur, m_sel_n, m_start_n;
  bit          m_txn;
  logic [9:0]  m_x [4];
  logic [9:0]  m_y [4];
  logic [2:0]  m_b [4];
  logic        e_start;
  logic [1:0]  e_sel;
  logic [39:0] e_tx;
  logic [3:0]  e_upd, e_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_n = 0; m_last = 3; m_cur = 0; m_txn = 0; m_sel_n = 0; m_start_n = -1;
      e_start = 0; e_sel = '0; e_tx = '0; e_upd = '0; e_err = '0;
      for (int k = 0; k < 4; k++) begin
        m_x[k] = '0; m_y[k] = '0; m_b[k] = '0;
      end
    end else begin
      bit m_tick;
      bit found;
      m_tick = (m_cnt == POLL_DIV - 1);
      m_cnt  = m_tick ? 0 : m_cnt + 1;
      m_n++;
      e_start = 1'b0;
      e_upd   = '0;
      if (!m_txn) begin
        if (m_tick && ch_en != 4'b0) begin
          found = 0;
          for (int i = 1; i <= 4; i++) begin
            if (!found && ch_en[(m_last + i) % 4]) begin
              found = 1;
              m_cur = (m_last + i) % 4;
            end
          end
          m_txn = 1; m_sel_n = m_n; m_start_n = -1;
          e_sel = 2'(m_cur);
          e_tx  = {6'b100000, led_cmd[2*m_cur +: 2], 32'h0};
        end
      end else if (m_start_n < 0) begin
        if (m_n - m_sel_n > SETUP_CYC && !spi_busy) begin
          m_start_n = m_n;
          e_start   = 1'b1;
        end
      end else if (spi_done) begin
        m_x[m_cur]   = {spi_rx[25:24], spi_rx[39:32]};
        m_y[m_cur]   = {spi_rx[9:8], spi_rx[23:16]};
        m_b[m_cur]   = spi_rx[2:0];
        e_upd[m_cur] = 1'b1;
        e_err[m_cur] = 1'b0;
        m_last = m_cur; m_txn = 0;
      end else if (m_n - m_start_n >= TIMEOUT) begin
        e_err[m_cur] = 1'b1;
        m_last = m_cur; m_txn = 0;
      end
    end
  end

  // ---------------- Compare + monitor ----------------
  int         cyc = 0;
  int         mon_starts, mon_upds, err1_rise_cyc;
  int         mon_upd_ch [4];
  int         last_start_cyc [4];
  logic [1:0] sel_q [$];
  logic [39:0] last_tx;
  logic [3:0] prev_err;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      check("start_in_reset", 64'(spi_start), 64'(0));
      mon_starts = 0; mon_upds = 0; err1_rise_cyc = 0; prev_err = '0; last_tx = '0;
      for (int k = 0; k < 4; k++) begin
        mon_upd_ch[k] = 0; last_start_cyc[k] = 0;
      end
      sel_q.delete();
    end else begin
      check("spi_start", 64'(spi_start), 64'(e_start));
      check("spi_sel", 64'(spi_sel), 64'(e_sel));
      check("spi_tx", 64'(spi_tx), 64'(e_tx));
      check("x_pos", 64'(x_pos), 64'({m_x[3], m_x[2], m_x[1], m_x[0]}));
      check("y_pos", 64'(y_pos), 64'({m_y[3], m_y[2], m_y[1], m_y[0]}));
      check("btn", 64'(btn), 64'({m_b[3], m_b[2], m_b[1], m_b[0]}));
      check("upd", 64'(upd), 64'(e_upd));
      check("timeout_err", 64'(timeout_err), 64'(e_err));
      if (spi_start) begin
        mon_starts++;
        sel_q.push_back(spi_sel);
        last_tx = spi_tx;
        last_start_cyc[spi_sel] = cyc;
      end
      for (int k = 0; k < 4; k++) begin
        if (upd[k]) begin
          mon_upds++;
          mon_upd_ch[k]++;
        end
      end
      if (timeout_err[1] && !prev_err[1]) err1_rise_cyc = cyc;
      prev_err = timeout_err;
    end
  end

  // ---------------- Helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, 64'({spi_start, spi_sel, upd, timeout_err}), 64'(0));
    check({name, "_tx"}, 64'(spi_tx), 64'(0));
    check({name, "_x"}, 64'(x_pos), 64'(0));
    check({name, "_y"}, 64'(y_pos), 64'(0));
    check({name, "_btn"}, 64'(btn), 64'(0));
  endtask

  // kind 0: starts >= target, 1: total upd >= target, 2: ch1 upd >= target, 3: timeout_err[1]
  task automatic wait_for(input int kind, input int target, input int budget, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      case (kind)
        0: ok = (mon_starts >= target);
        1: ok = (mon_upds >= target);
        2: ok = (mon_upd_ch[1] >= target);
        default: ok = (timeout_err[1] === 1'b1);
      endcase
    end
    check({name, "_reached"}, 64'(ok), 64'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- Directed and random scenarios ----------------
  initial begin
    int n0, t_fall;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset");

    // Round robin over all four channels
    ch_en = 4'b1111; resp_lat = 20; silent = '0;
    do_reset();
    wait_for(1, 5, 1000, "rr");
    check("rr_count", 64'(sel_q.size()), 64'(5));
    for (int i = 0; i < 5; i++) check($sformatf("rr_sel%0d", i), 64'(sel_q[i]), 64'(i % 4));
    check("rr_upds", 64'(mon_upds), 64'(5));
    check("rr_upd_ch0", 64'(mon_upd_ch[0]), 64'(2));
    check("rr_x", 64'(x_pos), 64'({4{10'h23C}}));
    check("rr_y", 64'(y_pos), 64'({4{10'h110}}));
    check("rr_btn", 64'(btn), 64'({4{3'b101}}));

    // Sparse mask, then empty mask
    ch_en = 4'b0101;
    do_reset();
    wait_for(1, 4, 1000, "sparse");
    for (int i = 0; i < 4; i++) check($sformatf("sparse_sel%0d", i), 64'(sel_q[i]), 64'((i % 2) * 2));
    ch_en = 4'b0000;
    n0 = mon_starts;
    repeat (10 * POLL_DIV) @(negedge clk);
    check("mask0_no_start", 64'(mon_starts - n0), 64'(0));

    // Timeout on channel 1 and recovery
    ch_en = 4'b1111; silent = '0;
    do_reset();
    wait_for(2, 1, 1000, "tmo_first_ch1");
    silent = 4'b0010;
    wait_for(3, 1, 1000, "tmo_flag");
    check("tmo_err", 64'(timeout_err), 64'(4'b0010));
    check("tmo_delay", 64'(err1_rise_cyc - last_start_cyc[1]), 64'(TIMEOUT));
    check("tmo_x_kept", 64'(x_pos[19:10]), 64'(10'h23C));
    check("tmo_no_upd", 64'(mon_upd_ch[1]), 64'(1));
    n0 = mon_starts;
    wait_for(0, n0 + 1, 1000, "tmo_next");
    check("tmo_next_sel", 64'(sel_q[sel_q.size() - 1]), 64'(2));
    silent = '0;
    wait_for(2, 2, 1000, "tmo_recover");
    check("tmo_cleared", 64'(timeout_err), 64'(0));

    // Busy hold-off at START, tick dropped during a long WAIT
    ch_en = 4'b0001; resp_lat = 40; force_busy = 1'b1;
    do_reset();
    repeat (50) @(negedge clk);
    check("busy_no_start", 64'(mon_starts), 64'(0));
    force_busy = 1'b0;
    t_fall = cyc;
    wait_for(0, 1, 100, "busy_start");
    check("busy_start_delay", 64'(last_start_cyc[0] - t_fall), 64'(1));
    wait_for(1, 1, 200, "busy_done");
    check("drop_tick_one_start", 64'(mon_starts), 64'(1));

    // TX frame contents and led_cmd sampling
    ch_en = 4'b0011; led_cmd = 8'b0000_1100; resp_lat = 20;
    do_reset();
    wait_for(0, 1, 200, "tx_first");
    check("tx_ch0", 64'(last_tx), 64'(40'h80_0000_0000));
    wait_for(0, 2, 200, "tx_second");
    check("tx_ch1", 64'(last_tx), 64'(40'h83_0000_0000));
    led_cmd = 8'hFF;
    repeat (5) @(negedge clk);
    check("tx_frozen", 64'(spi_tx), 64'(40'h83_0000_0000));

    // Asynchronous reset in the middle of a transfer
    ch_en = 4'b1111; led_cmd = 8'h00;
    wait_for(0, 3, 200, "pre_reset");
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check_all_zero("midrun_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_for(0, 1, 200, "post_reset");
    check("post_reset_sel", 64'(sel_q[0]), 64'(0));

    // Randomized traffic against the reference model
    rand_mode = 1'b1; ch_en = 4'b1111; silent = '0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      led_cmd = 8'($urandom);
      if ($urandom_range(0, 99) == 0) ch_en = 4'($urandom);
      if ($urandom_range(0, 299) == 0) silent = 4'($urandom) & 4'($urandom);
    end
    rand_mode = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jstk_poll_scheduler.md
Name: jstk_poll_scheduler

Overview:
- Round-robin scheduler that shares one SPI master engine among four joystick (PmodJSTK-style) channels.
- Selects a channel, drives its slave-select index and LED command frame, and starts a 5-byte transfer.
- Waits for completion, then unpacks the received frame into per-channel X/Y/button registers.
- Sits between the single SPI master core and game logic; replaces per-joystick free-running SPI masters.

Parameters:
- N_CH, 4: number of joystick channels; fixed at 4, sizes all per-channel buses.
- POLL_DIV, 100000: clk cycles between poll ticks. One transfer is launched per tick.
- SETUP_CYC, 8: cycles spi_sel/spi_tx are held stable before spi_start.
- TIMEOUT, 4096: cycles allowed in WAIT before the transfer is abandoned.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ch_en  in  4  per-channel poll enable
- led_cmd  in  8  LED bits, 2 per channel; ch k = [2k+1:2k]
- spi_busy  in  1  SPI master busy
- spi_done  in  1  one-cycle pulse: transfer complete, spi_rx valid
- spi_rx  in  40  received frame; byte0 = [39:32] ... byte4 = [7:0]
- spi_start  out  1  one-cycle transfer start pulse
- spi_sel  out  2  active channel index (drives SS demux)
- spi_tx  out  40  transmit frame
- x_pos  out  40  10-bit X per channel; ch k = [10k+9:10k]
- y_pos  out  40  10-bit Y per channel, same packing
- btn  out  12  3 button bits per channel; ch k = [3k+2:3k]
- upd  out  4  one-cycle strobe, channel k data refreshed
- timeout_err  out  4  per-channel sticky timeout flag

Behaviour:
- Clock and reset: clk is the only clock. rst is asynchronous and active-high.
- Reset values:
  - All outputs are 0.
  - State = IDLE, tick counter = 0.
  - Last-served pointer = 3, so channel 0 is served first.
- Tick counter:
  - Free-running, counts 0..POLL_DIV-1 and wraps.
  - tick = 1 for exactly one cycle when the count equals POLL_DIV-1.
- State machine: IDLE, SETUP, START, WAIT.
  - IDLE, on tick: pick the first enabled channel, searching from (last+1) mod 4 upward with wrap.
    - If one is found: latch it as cur, register spi_sel = cur and spi_tx = {6'b100000, led_cmd[cur], 32'h0}, go to SETUP.
    - If ch_en == 0: stay in IDLE.
  - SETUP: count SETUP_CYC cycles, then go to START. spi_sel and spi_tx stay frozen until the next channel is selected.
  - START: wait while spi_busy = 1. When spi_busy = 0, assert spi_start for one cycle, clear the timeout counter, go to WAIT.
  - WAIT, when spi_done is sampled high:
    - Capture spi_rx into channel cur: x = {rx[25:24], rx[39:32]}, y = {rx[9:8], rx[23:16]}, btn = rx[2:0].
    - Clear timeout_err[cur], set last = cur, go to IDLE.
    - upd[cur] is high in the cycle the new values first appear, and only that cycle.
  - WAIT, if the timeout counter reaches TIMEOUT-1 with no spi_done:
    - Set timeout_err[cur]; channel data is unchanged; no upd pulse.
    - Set last = cur, go to IDLE.
- Latency: a tick sampled in IDLE at edge T gives spi_start high in cycle T+1+SETUP_CYC, provided spi_busy is low.
- Boundary conditions:
  - A tick that arrives outside IDLE is dropped, not queued.
  - spi_done outside WAIT is ignored.
  - ch_en[cur] falling mid-transfer: the transfer completes and its result is stored.
  - led_cmd is sampled only at selection.
  - timeout_err[k] is cleared only by reset or by a successful transfer on channel k.
  - rst during any state forces the reset values immediately. spi_start never glitches high during reset.
- Area: the unpack logic is a single shared mux indexed by cur; there is no per-channel datapath duplication.

Test Plan:
1. Reset: assert rst mid-run -> all outputs 0 at once. After release, the first transfer has spi_sel = 0.
2. Round-robin over all channels:
   - Setup: POLL_DIV = 16, SETUP_CYC = 2, ch_en = 4'b1111; responder returns spi_rx = 40'h3C_02_10_01_05 after 20 cycles.
   - Required: spi_sel sequence 0,1,2,3,0; each channel gets x = 10'h23C, y = 10'h110, btn = 3'b101; one upd pulse per transfer.
3. Sparse mask: ch_en = 4'b0101 -> sel sequence 0,2,0,2. Then ch_en = 0 -> no spi_start over 10 ticks.
4. Timeout and recovery:
   - Setup: TIMEOUT = 64; responder silent on channel 1.
   - Required: timeout_err = 4'b0010 exactly 64 cycles after spi_start; x_pos[19:10] unchanged; upd[1] never pulses; next sel = 2.
   - Re-enable the responder -> the next successful channel-1 transfer clears timeout_err[1].
5. Busy hold-off: hold spi_busy = 1 for 30 cycles at START -> spi_start waits until the cycle after busy falls. A tick during WAIT is dropped: no extra transfer.
6. TX frame: led_cmd = 8'b00_00_11_00 -> the channel-1 transfer carries spi_tx = 40'h83_00000000 and channel 0 carries 40'h80_00000000. Changing led_cmd during WAIT leaves spi_tx unchanged.
